spsram_arb2: RTL and testbench
==============================

Name: spsram_arb2

Overview:
- Two-requester arbiter that shares one single-port SRAM macro between two masters.
- Each requester port carries the same signal set as the AHB-to-SRAM bridge's sram_* side; typical masters are the AHB bridge and a DMA/secondary bridge.
- Captures single-cycle request pulses, grants round-robin, and issues one transaction to the macro at a time.
- Routes each write-done/read-valid completion back to its owner and recovers from a missing completion with a timeout.

Parameters:
- AW, 14, word address width
- DW, 32, data width (mask width = DW/8)
- TIMEOUT_CYC, 255, max cycles waiting for a completion; 0 disables the timeout
- ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  reset
- rq_addr[i] (i=0,1)  in  AW  request word address
- rq_we[i]  in  1  write request pulse, one cycle
- rq_re[i]  in  1  read request pulse, one cycle
- rq_maskwe[i]  in  DW/8  byte write enables
- rq_din[i]  in  DW  write data, sampled with rq_we
- rq_dout[i]  out  DW  read data
- rq_write_done[i]  out  1  write completion pulse
- rq_read_valid[i]  out  1  read data valid pulse
- rq_ovf[i]  out  1  pulse: request dropped because slot was occupied
- mem_addr  out  AW  macro address
- mem_we  out  1  macro write strobe
- mem_re  out  1  macro read strobe
- mem_maskwe  out  DW/8  macro byte enables
- mem_din  out  DW  macro write data
- mem_dout  in  DW  macro read data
- mem_write_done  in  1  macro write completion
- mem_read_valid  in  1  macro read completion
- timeout  out  1  pulse: a transaction was force-completed

Behaviour:
- Reset: HRESETn (asynchronous, active-low), clock HCLK.
- On reset, all outputs are 0 except rq_dout/mem_din/mem_addr, which are also 0. Slots are empty, state is IDLE, last_grant=1 (so port 0 wins first), timeout counter is 0.
- Slot capture (per port):
  - A cycle with rq_we|rq_re high latches addr, din, maskwe and op into the slot; op=WR if rq_we, else RD (rq_we wins when both are high).
  - Slot becomes valid at the next edge.
  - Pulse while the slot is valid and not being released this cycle: request dropped, slot unchanged, rq_ovf pulses next cycle.
  - Pulse in the same cycle the slot is released: the new request is captured (capture wins), no rq_ovf.
- FSM states: IDLE, WAIT.
  - IDLE, no valid slot: stay.
  - IDLE, one valid slot: grant it.
  - IDLE, both valid: grant the port != last_grant.
  - On grant, registered mem_* are loaded at the edge and go to WAIT. mem_we or mem_re is high for exactly the first WAIT cycle; mem_addr/maskwe/din hold for all of WAIT. last_grant is updated to the granted port.
  - WAIT, mem_write_done|mem_read_valid high:
    - Combinationally in the same cycle: assert the owner's rq_write_done (op WR) or rq_read_valid (op RD), and drive rq_dout[owner]=mem_dout.
    - At the edge: release the owner's slot, clear mem_*, go to IDLE.
  - WAIT, TIMEOUT_CYC!=0 and counter==TIMEOUT_CYC-1 with no completion: same as a completion, with rq_dout=ERR_DATA for reads; timeout pulses that cycle.
  - Counter clears on entry to WAIT and increments each WAIT cycle.
- Completion inputs seen in IDLE are ignored. The non-owner's rq_write_done/rq_read_valid are always 0.
- Latency, request pulse at cycle N with slot free and IDLE:
  - mem strobe at N+2.
  - If the macro completes at N+2+k, the requester sees completion at N+2+k.
  - Minimum back-to-back spacing at the macro is 3 cycles (WAIT, IDLE, WAIT).
- rq_dout is 0 whenever that port's completion is not asserted.
- Reset mid-transaction aborts immediately: no completion is ever delivered and slots are cleared.

Decomposition:
- Package spsram_arb_pkg:
  - state enum {IDLE, WAIT}
  - op enum {RD, WR}
  - ERR_DATA default
  - slot struct {valid, op, addr, maskwe, din}
- Sub-module spsram_arb_slot: one per port; handles capture, release, overflow detection, and the capture-wins rule. Instantiated twice.
- The top level holds the FSM, round-robin pointer, timeout counter and completion routing.

Test Plan:
- Port0 write addr 0x0010 data 0x12345678 mask 4'hF, macro done 2 cycles after strobe -> mem_we one pulse with those fields; rq_write_done[0] in the same cycle as mem_write_done; rq_write_done[1]=0.
- Port0 and port1 read pulses in the same cycle (addr 0x0001, 0x0002) after reset -> port0 granted first, port1 next; mem_re pulses 3+ cycles apart; each rq_read_valid carries its own mem_dout (0xAAAA0001, 0xBBBB0002).
- Port1 issues a second pulse while its first is pending -> rq_ovf[1] pulses once; only one macro access for port1.
- Port0 new pulse in the cycle its completion arrives -> captured, no rq_ovf, second access issued.
- TIMEOUT_CYC=4, macro never completes a read -> after 4 WAIT cycles rq_read_valid pulses with rq_dout=0xDEADBEEF, timeout pulses, FSM back in IDLE.
- Assert HRESETn low during WAIT -> all mem_* and rq_* outputs 0 immediately; after release, port0 wins the first grant.

Source files
------------

// File: rtl/spsram_arb_pkg.sv
// Shared types for the two-port single-port-SRAM arbiter: FSM states, op codes
// and the per-port request slot. Slot field widths set the arbiter's AW/DW.
package spsram_arb_pkg;

  localparam int SLOT_AW = 14;
  localparam int SLOT_DW = 32;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  typedef enum logic {IDLE, WAIT} state_e;
  typedef enum logic {RD, WR} op_e;

  typedef struct packed {
    logic                   valid;
    op_e                    op;
    logic [SLOT_AW-1:0]     addr;
    logic [SLOT_DW/8-1:0]   maskwe;
    logic [SLOT_DW-1:0]     din;
  } slot_t;

endpackage

// File: rtl/spsram_arb_slot.sv
// One request slot: latches a single-cycle request pulse, holds it until the
// arbiter releases it, and flags pulses that arrive while it is still occupied.
module spsram_arb_slot
  import spsram_arb_pkg::*;
(
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [SLOT_AW-1:0]   i_addr,
  input  logic                 i_we,
  input  logic                 i_re,
  input  logic [SLOT_DW/8-1:0] i_maskwe,
  input  logic [SLOT_DW-1:0]   i_din,
  input  logic                 i_release,
  output slot_t                o_slot,
  output logic                 o_ovf
);

  slot_t r_slot;
  logic  r_ovf;
  logic  w_pulse;
  logic  w_busy;

  assign w_pulse = i_we | i_re;
  // A slot being released this cycle is free for a new capture.
  assign w_busy  = r_slot.valid & ~i_release;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_slot <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_ovf <= w_pulse & w_busy;
      if (w_pulse && !w_busy) begin
        r_slot.valid  <= 1'b1;
        r_slot.op     <= i_we ? WR : RD;
        r_slot.addr   <= i_addr;
        r_slot.maskwe <= i_maskwe;
        r_slot.din    <= i_din;
      end else if (i_release) begin
        r_slot.valid <= 1'b0;
      end
    end
  end

  assign o_slot = r_slot;
  assign o_ovf  = r_ovf;

endmodule

// File: rtl/spsram_arb2.sv
// Round-robin arbiter sharing one single-port SRAM macro between two masters,
// with completion routing back to the owner and a completion timeout.
module spsram_arb2
  import spsram_arb_pkg::*;
#(
  parameter int            AW          = SLOT_AW,
  parameter int            DW          = SLOT_DW,
  parameter int            TIMEOUT_CYC = 255,
  parameter logic [DW-1:0] ERR_DATA    = DW'(ERR_DATA_DEF)
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic [AW-1:0]   i_rq_addr       [2],
  input  logic            i_rq_we         [2],
  input  logic            i_rq_re         [2],
  input  logic [DW/8-1:0] i_rq_maskwe     [2],
  input  logic [DW-1:0]   i_rq_din        [2],
  output logic [DW-1:0]   o_rq_dout       [2],
  output logic            o_rq_write_done [2],
  output logic            o_rq_read_valid [2],
  output logic            o_rq_ovf        [2],
  output logic [AW-1:0]   o_mem_addr,
  output logic            o_mem_we,
  output logic            o_mem_re,
  output logic [DW/8-1:0] o_mem_maskwe,
  output logic [DW-1:0]   o_mem_din,
  input  logic [DW-1:0]   i_mem_dout,
  input  logic            i_mem_write_done,
  input  logic            i_mem_read_valid,
  output logic            o_timeout
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  slot_t           w_slot    [2];
  logic            w_release [2];
  slot_t           w_sel;
  logic            w_grant_any;
  logic            w_grant;
  logic            w_done;
  logic            w_to;
  logic            w_fin;

  state_e          r_state;
  logic            r_last;
  logic            r_owner;
  op_e             r_op;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_mem_addr;
  logic            r_mem_we;
  logic            r_mem_re;
  logic [DW/8-1:0] r_mem_maskwe;
  logic [DW-1:0]   r_mem_din;

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_slot
      spsram_arb_slot u_slot (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .i_addr    (i_rq_addr[g]),
        .i_we      (i_rq_we[g]),
        .i_re      (i_rq_re[g]),
        .i_maskwe  (i_rq_maskwe[g]),
        .i_din     (i_rq_din[g]),
        .i_release (w_release[g]),
        .o_slot    (w_slot[g]),
        .o_ovf     (o_rq_ovf[g])
      );
    end
  endgenerate

  // With both slots pending, the port that did not win last time goes next.
  always_comb begin
    w_grant_any = w_slot[0].valid | w_slot[1].valid;
    if (w_slot[0].valid && w_slot[1].valid) w_grant = ~r_last;
    else                                     w_grant = w_slot[1].valid;
    w_sel = w_slot[w_grant];
  end

  assign w_done    = i_mem_write_done | i_mem_read_valid;
  assign w_to      = (TIMEOUT_CYC != 0) && (r_cnt == CW'(TIMEOUT_CYC - 1)) && !w_done;
  assign w_fin     = (r_state == WAIT) && (w_done || w_to);
  assign o_timeout = (r_state == WAIT) && w_to;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_release[i]       = w_fin && (r_owner == i[0]);
      o_rq_write_done[i] = w_release[i] && (r_op == WR);
      o_rq_read_valid[i] = w_release[i] && (r_op == RD);
      o_rq_dout[i]       = '0;
      if (w_release[i]) begin
        if (w_done)          o_rq_dout[i] = i_mem_dout;
        else if (r_op == RD) o_rq_dout[i] = ERR_DATA;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state      <= IDLE;
      r_last       <= 1'b1;
      r_owner      <= 1'b0;
      r_op         <= RD;
      r_cnt        <= '0;
      r_mem_addr   <= '0;
      r_mem_we     <= 1'b0;
      r_mem_re     <= 1'b0;
      r_mem_maskwe <= '0;
      r_mem_din    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_any) begin
            r_state      <= WAIT;
            r_owner      <= w_grant;
            r_last       <= w_grant;
            r_op         <= w_sel.op;
            r_cnt        <= '0;
            r_mem_addr   <= w_sel.addr;
            r_mem_we     <= (w_sel.op == WR);
            r_mem_re     <= (w_sel.op == RD);
            r_mem_maskwe <= w_sel.maskwe;
            r_mem_din    <= w_sel.din;
          end
        end
        WAIT: begin
          // Strobe lasts only the first WAIT cycle; address/data hold until done.
          r_mem_we <= 1'b0;
          r_mem_re <= 1'b0;
          if (w_done || w_to) begin
            r_state      <= IDLE;
            r_mem_addr   <= '0;
            r_mem_maskwe <= '0;
            r_mem_din    <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  assign o_mem_addr   = r_mem_addr;
  assign o_mem_we     = r_mem_we;
  assign o_mem_re     = r_mem_re;
  assign o_mem_maskwe = r_mem_maskwe;
  assign o_mem_din    = r_mem_din;

endmodule

// File: tb/tb_spsram_arb2.sv
// Directed bench for spsram_arb2: fixed cycle-by-cycle scenarios with
// hand-computed expectations, built with TIMEOUT_CYC=4.
module tb_spsram_arb2;

  localparam int AW = 14;
  localparam int DW = 32;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic [AW-1:0] rq_addr       [2];
  logic          rq_we         [2];
  logic          rq_re         [2];
  logic [3:0]    rq_maskwe     [2];
  logic [31:0]   rq_din        [2];
  logic [31:0]   rq_dout       [2];
  logic          rq_write_done [2];
  logic          rq_read_valid [2];
  logic          rq_ovf        [2];
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic          mem_re;
  logic [3:0]    mem_maskwe;
  logic [31:0]   mem_din;
  logic [31:0]   mem_dout;
  logic          mem_write_done;
  logic          mem_read_valid;
  logic          timeout;

  int n_vec = 0;
  int n_err = 0;

  always #5 HCLK = ~HCLK;

  spsram_arb2 #(
    .AW(AW), .DW(DW), .TIMEOUT_CYC(4), .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .HCLK             (HCLK),
    .HRESETn          (HRESETn),
    .i_rq_addr        (rq_addr),
    .i_rq_we          (rq_we),
    .i_rq_re          (rq_re),
    .i_rq_maskwe      (rq_maskwe),
    .i_rq_din         (rq_din),
    .o_rq_dout        (rq_dout),
    .o_rq_write_done  (rq_write_done),
    .o_rq_read_valid  (rq_read_valid),
    .o_rq_ovf         (rq_ovf),
    .o_mem_addr       (mem_addr),
    .o_mem_we         (mem_we),
    .o_mem_re         (mem_re),
    .o_mem_maskwe     (mem_maskwe),
    .o_mem_din        (mem_din),
    .i_mem_dout       (mem_dout),
    .i_mem_write_done (mem_write_done),
    .i_mem_read_valid (mem_read_valid),
    .o_timeout        (timeout)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to 2ns after the next rising edge and drop all one-cycle pulses.
  task automatic nxt();
    @(posedge HCLK);
    #2;
    for (int i = 0; i < 2; i++) begin
      rq_we[i] = 1'b0;
      rq_re[i] = 1'b0;
    end
    mem_write_done = 1'b0;
    mem_read_valid = 1'b0;
    mem_dout       = '0;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic req(input int p, input logic we, input logic [AW-1:0] a,
                     input logic [31:0] d, input logic [3:0] m);
    rq_we[p]     = we;
    rq_re[p]     = ~we;
    rq_addr[p]   = a;
    rq_din[p]    = d;
    rq_maskwe[p] = m;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rq_addr[i] = '0; rq_we[i] = 1'b0; rq_re[i] = 1'b0;
      rq_maskwe[i] = '0; rq_din[i] = '0;
    end
    mem_dout = '0; mem_write_done = 1'b0; mem_read_valid = 1'b0;

    // Reset state
    nxt(); nxt(); settle();
    check_val("rst_mem_addr", 32'(mem_addr), 32'h0);
    check_val("rst_mem_we", 32'(mem_we), 32'h0);
    check_val("rst_mem_re", 32'(mem_re), 32'h0);
    check_val("rst_mem_din", mem_din, 32'h0);
    check_val("rst_timeout", 32'(timeout), 32'h0);
    check_val("rst_ovf0", 32'(rq_ovf[0]), 32'h0);
    check_val("rst_dout0", rq_dout[0], 32'h0);
    nxt(); HRESETn = 1'b1;

    // Simultaneous reads after reset: port0 first, then port1
    nxt(); req(0, 1'b0, 14'h0001, 32'h0, 4'h0); req(1, 1'b0, 14'h0002, 32'h0, 4'h0); settle();
    nxt(); settle();
    check_val("rr_c1_mem_re", 32'(mem_re), 32'h0);
    nxt(); settle();
    check_val("rr_c2_mem_re", 32'(mem_re), 32'h1);
    check_val("rr_c2_addr", 32'(mem_addr), 32'h1);
    nxt(); settle();
    check_val("rr_c3_mem_re", 32'(mem_re), 32'h0);
    nxt(); mem_read_valid = 1'b1; mem_dout = 32'hAAAA_0001; settle();
    check_val("rr_rv0", 32'(rq_read_valid[0]), 32'h1);
    check_val("rr_dout0", rq_dout[0], 32'hAAAA_0001);
    check_val("rr_rv1_idle", 32'(rq_read_valid[1]), 32'h0);
    check_val("rr_dout1_idle", rq_dout[1], 32'h0);
    nxt(); settle();
    check_val("rr_c5_mem_re", 32'(mem_re), 32'h0);
    check_val("rr_c5_rv0", 32'(rq_read_valid[0]), 32'h0);
    check_val("rr_c5_dout0", rq_dout[0], 32'h0);
    nxt(); settle();
    check_val("rr_c6_mem_re", 32'(mem_re), 32'h1);
    check_val("rr_c6_addr", 32'(mem_addr), 32'h2);
    nxt();
    nxt(); mem_read_valid = 1'b1; mem_dout = 32'hBBBB_0002; settle();
    check_val("rr_rv1", 32'(rq_read_valid[1]), 32'h1);
    check_val("rr_dout1", rq_dout[1], 32'hBBBB_0002);
    check_val("rr_rv0_idle", 32'(rq_read_valid[0]), 32'h0);
    check_val("rr_dout0_idle", rq_dout[0], 32'h0);
    nxt();

    // Port0 write, macro done 2 cycles after the strobe
    nxt(); req(0, 1'b1, 14'h0010, 32'h1234_5678, 4'hF); settle();
    nxt(); settle();
    check_val("wr_c1_mem_we", 32'(mem_we), 32'h0);
    nxt(); settle();
    check_val("wr_c2_mem_we", 32'(mem_we), 32'h1);
    check_val("wr_c2_addr", 32'(mem_addr), 32'h10);
    check_val("wr_c2_din", mem_din, 32'h1234_5678);
    check_val("wr_c2_mask", 32'(mem_maskwe), 32'hF);
    nxt(); settle();
    check_val("wr_c3_mem_we", 32'(mem_we), 32'h0);
    check_val("wr_c3_addr_hold", 32'(mem_addr), 32'h10);
    nxt(); mem_write_done = 1'b1; settle();
    check_val("wr_done0", 32'(rq_write_done[0]), 32'h1);
    check_val("wr_done1", 32'(rq_write_done[1]), 32'h0);
    check_val("wr_rv0", 32'(rq_read_valid[0]), 32'h0);
    nxt(); settle();
    check_val("wr_c5_done0", 32'(rq_write_done[0]), 32'h0);
    check_val("wr_c5_addr_clr", 32'(mem_addr), 32'h0);

    // Port1 overflow while its slot is pending
    nxt(); req(1, 1'b1, 14'h0020, 32'h0000_0055, 4'h3); settle();
    nxt(); req(1, 1'b0, 14'h0021, 32'h0, 4'h0); settle();
    check_val("ovf_c1_ovf1", 32'(rq_ovf[1]), 32'h0);
    nxt(); settle();
    check_val("ovf_c2_ovf1", 32'(rq_ovf[1]), 32'h1);
    check_val("ovf_c2_ovf0", 32'(rq_ovf[0]), 32'h0);
    check_val("ovf_c2_mem_we", 32'(mem_we), 32'h1);
    check_val("ovf_c2_addr", 32'(mem_addr), 32'h20);
    check_val("ovf_c2_din", mem_din, 32'h55);
    check_val("ovf_c2_mask", 32'(mem_maskwe), 32'h3);
    nxt(); settle();
    check_val("ovf_c3_ovf1", 32'(rq_ovf[1]), 32'h0);
    nxt(); mem_write_done = 1'b1; settle();
    check_val("ovf_done1", 32'(rq_write_done[1]), 32'h1);
    check_val("ovf_done0", 32'(rq_write_done[0]), 32'h0);
    for (int c = 5; c < 8; c++) begin
      nxt(); settle();
      check_val($sformatf("ovf_c%0d_mem_re", c), 32'(mem_re), 32'h0);
      check_val($sformatf("ovf_c%0d_mem_we", c), 32'(mem_we), 32'h0);
    end

    // Port0 re-requests in the cycle its completion arrives
    nxt(); req(0, 1'b0, 14'h0030, 32'h0, 4'h0); settle();
    nxt();
    nxt(); settle();
    check_val("cw_c2_mem_re", 32'(mem_re), 32'h1);
    check_val("cw_c2_addr", 32'(mem_addr), 32'h30);
    nxt();
    nxt(); mem_read_valid = 1'b1; mem_dout = 32'h1111_0030;
    req(0, 1'b0, 14'h0031, 32'h0, 4'h0); settle();
    check_val("cw_rv0", 32'(rq_read_valid[0]), 32'h1);
    check_val("cw_dout0", rq_dout[0], 32'h1111_0030);
    nxt(); settle();
    check_val("cw_c5_ovf0", 32'(rq_ovf[0]), 32'h0);
    nxt(); settle();
    check_val("cw_c6_mem_re", 32'(mem_re), 32'h1);
    check_val("cw_c6_addr", 32'(mem_addr), 32'h31);
    nxt();
    nxt(); mem_read_valid = 1'b1; mem_dout = 32'h2222_0031; settle();
    check_val("cw_rv0_2", 32'(rq_read_valid[0]), 32'h1);
    check_val("cw_dout0_2", rq_dout[0], 32'h2222_0031);

    // Port1 read that never completes: timeout after 4 WAIT cycles
    nxt(); req(1, 1'b0, 14'h0040, 32'h0, 4'h0); settle();
    nxt();
    nxt(); settle();
    check_val("to_c2_mem_re", 32'(mem_re), 32'h1);
    check_val("to_c2_timeout", 32'(timeout), 32'h0);
    nxt();
    nxt(); settle();
    check_val("to_c4_timeout", 32'(timeout), 32'h0);
    check_val("to_c4_rv1", 32'(rq_read_valid[1]), 32'h0);
    nxt(); settle();
    check_val("to_c5_timeout", 32'(timeout), 32'h1);
    check_val("to_c5_rv1", 32'(rq_read_valid[1]), 32'h1);
    check_val("to_c5_dout1", rq_dout[1], 32'hDEAD_BEEF);
    check_val("to_c5_rv0", 32'(rq_read_valid[0]), 32'h0);
    nxt(); req(0, 1'b0, 14'h0050, 32'h0, 4'h0); settle();
    check_val("to_c6_timeout", 32'(timeout), 32'h0);
    check_val("to_c6_addr_clr", 32'(mem_addr), 32'h0);
    check_val("to_c6_rv1", 32'(rq_read_valid[1]), 32'h0);
    nxt();
    nxt(); settle();
    check_val("to_c8_mem_re", 32'(mem_re), 32'h1);
    check_val("to_c8_addr", 32'(mem_addr), 32'h50);

    // Reset asserted mid-WAIT, with a completion arriving at the same time
    nxt(); HRESETn = 1'b0; mem_read_valid = 1'b1; mem_dout = 32'h0000_0099; settle();
    check_val("mr_addr", 32'(mem_addr), 32'h0);
    check_val("mr_mem_re", 32'(mem_re), 32'h0);
    check_val("mr_rv0", 32'(rq_read_valid[0]), 32'h0);
    check_val("mr_dout0", rq_dout[0], 32'h0);
    check_val("mr_timeout", 32'(timeout), 32'h0);
    nxt();
    nxt(); HRESETn = 1'b1; settle();
    check_val("mr_rel_mem_re", 32'(mem_re), 32'h0);
    for (int c = 1; c < 3; c++) begin
      nxt(); settle();
      check_val($sformatf("mr_post%0d_mem_re", c), 32'(mem_re), 32'h0);
      check_val($sformatf("mr_post%0d_addr", c), 32'(mem_addr), 32'h0);
    end
    nxt(); req(0, 1'b1, 14'h0060, 32'h0000_0600, 4'hF);
    req(1, 1'b1, 14'h0061, 32'h0000_0610, 4'hF); settle();
    nxt();
    nxt(); settle();
    check_val("mr_first_we", 32'(mem_we), 32'h1);
    check_val("mr_first_addr", 32'(mem_addr), 32'h60);
    check_val("mr_first_din", mem_din, 32'h0000_0600);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
